// File: rtl/nibbler_pkg.sv
// nibbler_pkg: shared types for the nibble datapath serial port.
//   nibble_t   : 4-bit datapath word
//   tx_state_t : transmitter FSM states
// PARITY exists in the enum in every build. It is only reachable when the
// NIBBLE_TX_PARITY_EN macro is defined.
package nibbler_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/nibble_fifo.sv
// nibble_fifo: DEPTH-entry circular buffer of nibbles.
//   clk, reset : clock and synchronous active-high reset
//   push, din  : write strobe and data. A push while full is ignored,
//                unless a pop happens on the same edge.
//   pop        : removes the head entry. It is ignored while empty.
//   dout       : head entry. It is valid while !empty.
//   count      : number of entries held (0..DEPTH)
//   full/empty : count==DEPTH / count==0
import nibbler_pkg::*;

module nibble_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  nibble_t                  din,
    output nibble_t                  dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    nibble_t         mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            do_push;
    logic            do_pop;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    // When the buffer is full, a push on the same edge as a pop takes the slot
    // that the pop frees.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nibble_tx.sv
// nibble_tx: buffered UART-style serial output for accumulator nibbles.
// Each frame is a start bit (0), then D[0]..D[3] LSB first, then a stop bit (1).
// Every bit is held for DIV clocks.
// Compile-time option NIBBLE_TX_PARITY_EN: this adds an even-parity bit
// (XOR of D) before the stop bit.
//   clk      : system clock
//   reset    : synchronous, active-high. It aborts any frame in progress.
//   enable   : write strobe. D is captured on a rising edge while high.
//   D        : nibble to send
//   full     : buffer holds DEPTH nibbles
//   overflow : sticky. Set when a write is dropped because the buffer is full.
//   busy     : a frame is on the line or the buffer is non-empty
//   tx       : serial line. It idles high.
// Handshake: enable has no backpressure. A write is accepted if the buffer is
// not full, or if the transmitter pops on that same edge. Any other write is
// dropped and overflow is set.
import nibbler_pkg::*;

module nibble_tx #(
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    enable,
    input  nibble_t D,
    output logic    full,
    output logic    overflow,
    output logic    busy,
    output logic    tx
);

    localparam int PW = $clog2(DEPTH);

    tx_state_t       state;
    tx_state_t       state_next;
    logic [7:0]      div_cnt;
    logic [1:0]      bit_cnt;
    nibble_t         shift;
    logic            div_last;
    logic            pop;
    logic            empty;
    nibble_t         head;
    logic [PW:0]     count;
`ifdef NIBBLE_TX_PARITY_EN
    logic            par;
`endif

    nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (enable),
        .pop   (pop),
        .din   (D),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign div_last = (div_cnt == 8'(DIV - 1));
    assign busy     = (state != IDLE) || (count != '0);

    // Next-state logic and Moore outputs. tx depends only on registered state,
    // so the line returns to 1 on the edge where IDLE is entered.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (div_last) state_next = DATA;
            end
            DATA: begin
                tx = shift[0];
                if (div_last && bit_cnt == 2'd3) begin
`ifdef NIBBLE_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef NIBBLE_TX_PARITY_EN
            PARITY: begin
                tx = par;
                if (div_last) state_next = STOP;
            end
`endif
            STOP: begin
                tx = 1'b1;
                if (div_last) begin
                    // The next frame starts right after the stop bit, with no idle gap.
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (pop) begin
                shift   <= head;
                bit_cnt <= '0;
                div_cnt <= '0;
`ifdef NIBBLE_TX_PARITY_EN
                par     <= ^head;
`endif
            end else if (state != IDLE) begin
                if (div_last) begin
                    div_cnt <= '0;
                    if (state == DATA) begin
                        shift   <= {1'b0, shift[3:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            // A write is dropped only if the slot is not freed on the same edge.
            if (enable && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_tx.sv
// tb_nibble_tx: directed bench for nibble_tx (DIV=4, DEPTH=4).
// The stimulus queues the expected nibbles. The line monitor decodes every
// frame and checks it against the queue, one bit period at a time.
module tb_nibble_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef NIBBLE_TX_PARITY_EN
    localparam int FRAME_BITS = 7;
`else
    localparam int FRAME_BITS = 6;
`endif
    localparam int FRAME_CYC = FRAME_BITS * DIV;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] D;
    logic       full;
    logic       overflow;
    logic       busy;
    logic       tx;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    nibble_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .D        (D),
        .full     (full),
        .overflow (overflow),
        .busy     (busy),
        .tx       (tx)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives one write that is sampled on the next rising edge.
    // accept: whether the bench expects the nibble to reach the line.
    task automatic write_nib(input logic [3:0] d, input bit accept);
        if (accept) exp_q.push_back(d);
        enable = 1'b1;
        D      = d;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         in_frame = 0;
    int         cyc = 0;
    int         cycle_no = 0;
    int         last_end = 0;
    int         last_gap = 0;
    int         frames_done = 0;
    logic       bits [0:7];
    logic       bad = 0;
    logic [3:0] cur;

    always @(negedge clk) begin
        cycle_no++;
        if (reset) begin
            in_frame = 0;
            exp_q.delete();
        end else begin
            if (!in_frame && tx == 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame actual=start_bit required=idle at %0t", $time);
                    cur = 4'h0;
                end else begin
                    cur = exp_q.pop_front();
                end
                bits[0] = 1'b0;
                for (int i = 0; i < 4; i++) bits[i+1] = cur[i];
`ifdef NIBBLE_TX_PARITY_EN
                bits[5] = ^cur;
                bits[6] = 1'b1;
`else
                bits[5] = 1'b1;
`endif
                in_frame = 1;
                cyc      = 0;
                bad      = 0;
                last_gap = cycle_no - last_end;
            end
            if (in_frame) begin
                if (tx !== bits[cyc / DIV]) bad = 1;
                if ((cyc % DIV) == DIV - 1) begin
                    checks++;
                    if (bad) begin
                        errors++;
                        $display("FAIL frame_bit nibble=%0h bit=%0d actual=%b required=%b at %0t",
                                 cur, cyc / DIV, tx, bits[cyc / DIV], $time);
                    end
                    bad = 0;
                end
                cyc++;
                if (cyc == FRAME_CYC) begin
                    in_frame = 0;
                    last_end = cycle_no;
                    frames_done++;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy && !in_frame) done = 1;
        end
        check({name, "_idle_timeout"}, {31'd0, done}, 32'd1);
        check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int f0;
        reset  = 1'b0;
        enable = 1'b0;
        D      = 4'h0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);

        // Single frame 4'h3: latency and busy window
        write_nib(4'h3, 1);               // sampled at edge k
        check("lat_tx_k", tx, 1);
        check("lat_busy_k", busy, 1);
        @(posedge clk);
        #1;                               // after edge k+1
        check("lat_tx_k1", tx, 0);
        repeat (FRAME_CYC - 1) @(posedge clk);
        #1;
        check("busy_last_cycle", busy, 1);
        @(posedge clk);
        #1;
        check("busy_after_frame", busy, 0);
        check("tx_after_frame", tx, 1);
        wait_idle("single");

        // Back-to-back 4'h2, 4'hA: no idle gap
        f0 = frames_done;
        write_nib(4'h2, 1);
        write_nib(4'hA, 1);
        wait_idle("b2b");
        check("b2b_frames", frames_done - f0, 2);
        check("b2b_gap", last_gap, 1);

        // Overflow: 1..6 from idle; 6 is dropped
        write_nib(4'h1, 1);
        write_nib(4'h2, 1);
        write_nib(4'h3, 1);
        write_nib(4'h4, 1);
        check("ovf_not_full", full, 0);
        write_nib(4'h5, 1);
        check("ovf_full", full, 1);
        check("ovf_before", overflow, 0);
        write_nib(4'h6, 0);
        check("ovf_set", overflow, 1);
        wait_idle("ovf");
        check("ovf_sticky", overflow, 1);
        check("ovf_drained_full", full, 0);
        do_reset();
        check("ovf_cleared", overflow, 0);

        // Full plus simultaneous pop: the write on the stop-end edge is accepted
        write_nib(4'h8, 1);               // edge k, popped at k+1
        write_nib(4'h9, 1);
        write_nib(4'hB, 1);
        write_nib(4'hC, 1);
        write_nib(4'hD, 1);               // edge k+4, full
        check("fp_full_before", full, 1);
        repeat (FRAME_CYC - 4) @(posedge clk);
        #1;
        check("fp_still_full", full, 1);
        write_nib(4'hF, 1);               // sampled at edge k+1+FRAME_CYC
        check("fp_full_after", full, 1);
        check("fp_overflow", overflow, 0);
        wait_idle("fullpop");
        check("fp_overflow_end", overflow, 0);

        // Parity-relevant nibble (odd weight)
        write_nib(4'h7, 1);
        wait_idle("par7");

        // Reset 10 cycles into a frame aborts it
        write_nib(4'h5, 1);
        write_nib(4'h6, 1);
        repeat (9) @(posedge clk);
        #1;
        check("abort_mid_tx", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_full", full, 0);
        repeat (FRAME_CYC) @(posedge clk);
        #1;
        check("abort_stays_idle", busy, 0);
        check("abort_line_high", tx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_tx.md
Name: nibble_tx

Overview:
Serial output port for the nibble datapath. It captures the accumulator nibble whenever the core strobes a write, holds up to DEPTH nibbles, and shifts each one out on a single line as a UART-style frame.
- It is the reader/consumer side of the accumulator: the accumulator's Q drives this block's D.
- Lets programs emit 4-bit results off-chip without stalling the core.

Parameters:
DIV, 4, clock cycles per serial bit period; legal range 1..255.
DEPTH, 4, nibble buffer depth; must be a power of two, minimum 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  write strobe; D is captured on a rising edge while high
D  input  4  nibble to transmit (from the accumulator output)
full  output  1  buffer holds DEPTH nibbles
overflow  output  1  sticky flag: a write was dropped because the buffer was full
busy  output  1  high while a frame is on the line or the buffer is non-empty
tx  output  1  serial line; idles high

Behaviour:
- Reset (synchronous, active-high, one clk edge):
  - tx=1, busy=0, full=0, overflow=0.
  - Buffer emptied, bit and divider counters cleared, state=IDLE.
  - Reset asserted mid-frame aborts the frame; tx is high from the next edge.
- Frame format: start bit (0), D[0], D[1], D[2], D[3], stop bit (1).
  - Each bit is held exactly DIV cycles.
  - Frame length is 6*DIV cycles (7*DIV with the parity option).
- States:
  - IDLE: tx=1. If the buffer is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for DIV cycles, then DATA.
  - DATA: drive shift[0] for DIV cycles, shift right, bit count++. After 4 bits go to PARITY (option enabled) or STOP.
  - PARITY (option only): one bit period, then STOP.
  - STOP: tx=1 for DIV cycles. At the end, if the buffer is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: a write sampled at edge k into an empty buffer with the transmitter IDLE makes tx=0 visible after edge k+1.
- Write rules:
  - enable=1 and not full: push D.
  - enable=1 and full: drop the nibble and set overflow (held until reset).
  - Push and pop on the same edge while full: both happen, the write is accepted, overflow stays unchanged.
  - Push into an empty buffer on the same edge IDLE checks: the nibble is seen on the following edge, not bypassed.
- full = (count==DEPTH). busy = (state!=IDLE) or (count!=0).
- Counters: the divider counts 0..DIV-1. The buffer pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

Optional Feature:
NIBBLE_TX_PARITY_EN:
- Defined: insert an even-parity bit (XOR of D[3:0]) between D[3] and stop. Frame is 7*DIV cycles.
- Undefined: no PARITY state, frame is 6*DIV cycles, no parity logic synthesized.

Decomposition:
- Package nibbler_pkg:
  - typedef nibble_t (logic [3:0]).
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - localparam NIBBLE_W=4.
- Sub-module nibble_fifo (DEPTH param):
  - Inputs: clk, reset, push, pop, din.
  - Outputs: dout, count, full, empty.
  - Pushes when full are ignored internally; overflow is flagged in nibble_tx.
- nibble_tx holds the FSM, divider, shift register and overflow flag.

Test Plan:
- Reset check: reset=1 for 1 edge, then release -> tx=1, busy=0, full=0, overflow=0. Assert reset 10 cycles into a frame -> tx=1 from the next edge, busy=0, buffer empty.
- Single frame, DIV=4: write D=4'h3 at edge k -> from edge k+1, tx carries 0,1,1,0,0,1 with each bit 4 cycles. busy is high for 24 cycles, then 0.
- Back-to-back: write 4'h2 then 4'hA on consecutive edges -> frames 0,0,1,0,0,1 then 0,0,1,0,1,1 with no idle cycle between the stop bit and the next start bit.
- Overflow, DEPTH=4: 6 consecutive writes 4'h1..4'h6 starting from idle -> 4'h1 is popped immediately, 4'h2..4'h5 fill the buffer (full=1), 4'h6 is dropped and overflow=1. Transmitted order is 1,2,3,4,5 and overflow stays 1 until reset.
- Parity (NIBBLE_TX_PARITY_EN defined): D=4'h3 -> parity bit 0. D=4'h7 -> parity bit 1. Frame length 28 cycles at DIV=4.
- Full with simultaneous pop: fill the buffer, then write 4'hF on the edge where STOP ends and a pop occurs -> 4'hF accepted, full remains 1, overflow remains 0.
